// File: rtl/alu_step_controller_pkg.sv
// Shared types and constants for the ALU step controller.
package alu_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    EXEC,
    DONE
  } state_t;

  // Field positions inside the 15-bit program word {opcode, A, B}
  localparam int unsigned WORD_W = 15;
  localparam int unsigned OP_MSB = 14;
  localparam int unsigned A_MSB  = 11;
  localparam int unsigned B_MSB  = 5;

  localparam int unsigned DEF_ADDR_W   = 3;
  localparam int unsigned DEF_DATA_W   = 6;
  localparam int unsigned DEF_OP_W     = 3;
  localparam int unsigned DEF_TICK_DIV = 50000000;

endpackage

// File: rtl/alu_step_controller_key_edge_sync.sv
// Pushbutton synchroniser: two sync flops plus a falling-edge detector.
module key_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic step
);

  logic sync1;
  logic sync2;
  logic prev;

  // Synchronise the raw key and keep the previous synchronised value
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      prev  <= 1'b1;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  // One-cycle pulse on a synchronised high-to-low transition
  assign step = prev & ~sync2;

endmodule

// File: rtl/alu_step_controller.sv
// Program sequencer for the 6-bit ALU: program store, stepping FSM, result file.
module alu_step_controller
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned OP_W     = DEF_OP_W,
  parameter int unsigned TICK_DIV = DEF_TICK_DIV
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key,
  input  logic              rw,
  input  logic              run,
  input  logic [14:0]       i_data,
  input  logic [DATA_W-1:0] alu_c,
  output logic [OP_W-1:0]   instruction,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  output logic [ADDR_W-1:0] out_address,
  output logic [DATA_W-1:0] result,
  output logic              busy,
  output logic              done
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  state_t state;
  state_t state_nxt;

  logic              step;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] last_addr;
  logic [WORD_W-1:0] prog [DEPTH];
  logic [DATA_W-1:0] res  [DEPTH];
  logic [CNT_W-1:0]  tick_cnt;
  logic              tick_hit;
  logic              run_armed;
  logic              auto_op;
  logic              auto_go;
  logic              man_step;

  key_edge_sync u_key_edge_sync (
    .clk   (clk),
    .rst   (rst),
    .key_n (key),
    .step  (step)
  );

  assign out_address = addr;

  // Step qualifiers: auto-run owns the controller whenever run is high
  always_comb begin
    tick_hit = (tick_cnt == CNT_W'(TICK_DIV - 1));
    auto_go  = (state == IDLE) && run && run_armed && tick_hit;
    man_step = (state == IDLE) && !run && step;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (auto_go || (man_step && !rw)) state_nxt = LOAD;
      LOAD: state_nxt = EXEC;
      EXEC: state_nxt = (auto_op && run && (addr == '1)) ? DONE : IDLE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs; result is read from the result file at the last executed
  // address, which always equals the most recently captured ALU value
  always_comb begin
    busy   = (state == LOAD) || (state == EXEC);
    done   = (state == DONE);
    result = res[last_addr];
  end

  // Auto-run tick counter and re-arm flag (run must drop after a full pass)
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt  <= '0;
      run_armed <= 1'b1;
    end else begin
      if (!run)                 run_armed <= 1'b1;
      else if (state == DONE)   run_armed <= 1'b0;

      if (!run || !run_armed || (state != IDLE)) tick_cnt <= '0;
      else if (tick_hit)                         tick_cnt <= '0;
      else                                       tick_cnt <= tick_cnt + 1'b1;
    end
  end

  // Program store, operand registers, result file and address pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      addr        <= '0;
      last_addr   <= '0;
      instruction <= '0;
      A           <= '0;
      B           <= '0;
      auto_op     <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        prog[i[ADDR_W-1:0]] <= '0;
        res[i[ADDR_W-1:0]]  <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          auto_op <= auto_go;
          if (man_step && rw) begin
            prog[addr] <= i_data;
            addr       <= addr + 1'b1;
          end
        end
        LOAD: begin
          instruction <= prog[addr][OP_MSB -: OP_W];
          A           <= prog[addr][A_MSB -: DATA_W];
          B           <= prog[addr][B_MSB -: DATA_W];
        end
        EXEC: begin
          res[addr] <= alu_c;
          last_addr <= addr;
          // Natural wrap covers both "addr+1" and "7 -> 0 at end of auto-run"
          addr      <= addr + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_step_controller.sv
// Self-checking bench for alu_step_controller with an A+B ALU model.
module tb_alu_step_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        key;
  logic        rw;
  logic        run;
  logic [14:0] i_data;
  logic [5:0]  alu_c;
  logic [2:0]  instruction;
  logic [5:0]  A;
  logic [5:0]  B;
  logic [2:0]  out_address;
  logic [5:0]  result;
  logic        busy;
  logic        done;

  alu_step_controller #(
    .ADDR_W   (3),
    .DATA_W   (6),
    .OP_W     (3),
    .TICK_DIV (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .key         (key),
    .rw          (rw),
    .run         (run),
    .i_data      (i_data),
    .alu_c       (alu_c),
    .instruction (instruction),
    .A           (A),
    .B           (B),
    .out_address (out_address),
    .result      (result),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  // Bench ALU
  assign alu_c = A + B;

  typedef struct {
    logic [14:0] word;
    logic [2:0]  exp_addr;
  } wr_vec_t;

  typedef struct {
    logic [5:0] res;
    logic [2:0] addr;
    int         gap;
  } sb_t;

  wr_vec_t wv [8];
  sb_t     sbq [$];
  int      n_pass = 0;
  int      n_total = 0;
  int      done_cnt = 0;
  int      cyc = 0;
  int      last_cap = 0;
  logic    busy_q = 1'b0;
  logic    sb_on = 1'b1;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic logic [5:0] model_res(input logic [14:0] w);
    return w[11:6] + w[5:0];
  endfunction

  task automatic push_entry(input int idx, input int gap);
    sb_t e;
    e.res  = model_res(wv[idx].word);
    e.addr = wv[idx].exp_addr;
    e.gap  = gap;
    sbq.push_back(e);
  endtask

  // Monitor: a completed op shows as busy falling; compare against scoreboard
  always @(negedge clk) begin
    sb_t e;
    cyc++;
    if (sb_on && busy_q && !busy) begin
      check("sb_pending", int'(sbq.size() != 0), 1);
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        check("sb_result", result, e.res);
        check("sb_addr", out_address, e.addr);
        if (e.gap != 0) check("sb_gap", cyc - last_cap, e.gap);
      end
      last_cap = cyc;
    end
    if (done) begin
      done_cnt++;
      check("done_addr", out_address, 0);
    end
    busy_q = busy;
  end

  task automatic press();
    @(negedge clk) key = 1'b0;
    repeat (4) @(negedge clk);
    key = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_drain(input int budget);
    for (int c = 0; c < budget && sbq.size() != 0; c++) @(negedge clk);
    check("sb_drain", sbq.size(), 0);
    sbq.delete();
  endtask

  task automatic write_table();
    for (int k = 0; k < 8; k++) begin
      rw     = 1'b1;
      i_data = wv[k].word;
      press();
      check($sformatf("wr_addr%0d", k), out_address, wv[k].exp_addr);
      check("wr_A_hold", A, 0);
      check("wr_B_hold", B, 0);
    end
    rw = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got still running expected finished");
    $fatal(1);
  end

  initial begin
    wv[0].word     = 15'b001_000101_000011;
    wv[0].exp_addr = 3'd1;
    for (int k = 1; k < 8; k++) begin
      wv[k].word     = {k[2:0], 6'(k), 6'd1};
      wv[k].exp_addr = 3'((k + 1) % 8);
    end

    rst = 1'b1; key = 1'b1; rw = 1'b0; run = 1'b0; i_data = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_addr", out_address, 0);
    check("rst_instr", instruction, 0);
    check("rst_A", A, 0);
    check("rst_B", B, 0);
    check("rst_result", result, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);

    write_table();

    // Manual execute of entry 0 with cycle-exact latency
    rw = 1'b0;
    push_entry(0, 0);
    @(negedge clk) key = 1'b0;
    repeat (3) @(negedge clk);
    check("lat_load_busy", busy, 1);
    check("lat_load_instr", instruction, 0);
    @(negedge clk);
    check("lat_instr", instruction, 1);
    check("lat_A", A, 5);
    check("lat_B", B, 3);
    check("lat_exec_busy", busy, 1);
    @(negedge clk);
    check("lat_result", result, 8);
    check("lat_addr", out_address, 1);
    check("lat_busy_low", busy, 0);
    key = 1'b1;
    repeat (4) @(negedge clk);
    wait_drain(20);

    // Second press lands while busy and must be dropped
    push_entry(1, 0);
    @(negedge clk) key = 1'b0;
    @(negedge clk) key = 1'b1;
    @(negedge clk) key = 1'b0;
    @(negedge clk) key = 1'b1;
    repeat (10) @(negedge clk);
    wait_drain(20);
    check("drop_addr", out_address, 2);
    check("drop_result", result, 2);

    // Reset during LOAD
    sb_on = 1'b0;
    @(negedge clk) key = 1'b0;
    repeat (3) @(negedge clk);
    check("rl_pre_busy", busy, 1);
    rst = 1'b1;
    key = 1'b1;
    @(negedge clk);
    check("rl_addr", out_address, 0);
    check("rl_instr", instruction, 0);
    check("rl_A", A, 0);
    check("rl_B", B, 0);
    check("rl_result", result, 0);
    check("rl_busy", busy, 0);
    @(negedge clk) rst = 1'b0;
    repeat (2) @(negedge clk);
    sb_on = 1'b1;

    write_table();

    // Auto-run over the whole program
    for (int k = 0; k < 8; k++) push_entry(k, (k == 0) ? 0 : 6);
    @(negedge clk) run = 1'b1;
    wait_drain(120);
    @(negedge clk);
    check("auto1_done_cnt", done_cnt, 1);
    check("auto1_addr", out_address, 0);
    press();
    repeat (20) @(negedge clk);
    check("hold_addr", out_address, 0);
    check("hold_busy", busy, 0);
    check("hold_done_cnt", done_cnt, 1);

    // Re-arm by dropping run for one cycle
    @(negedge clk) run = 1'b0;
    for (int k = 0; k < 8; k++) push_entry(k, (k == 0) ? 0 : 6);
    @(negedge clk) run = 1'b1;
    wait_drain(120);
    @(negedge clk);
    check("auto2_done_cnt", done_cnt, 2);

    // Abort auto-run during EXEC of entry 3
    @(negedge clk) run = 1'b0;
    for (int k = 0; k < 4; k++) push_entry(k, (k == 0) ? 0 : 6);
    @(negedge clk) run = 1'b1;
    for (int c = 0; c < 80 && !(busy && A == 6'd3); c++) @(negedge clk);
    check("abort_reach", int'(busy && A == 6'd3), 1);
    run = 1'b0;
    wait_drain(20);
    repeat (2) @(negedge clk);
    check("abort_addr", out_address, 4);
    check("abort_busy", busy, 0);
    check("abort_result", result, 4);
    repeat (10) @(negedge clk);
    check("abort_idle_addr", out_address, 4);

    // Manual stepping resumes at entry 4
    rw = 1'b0;
    push_entry(4, 0);
    press();
    wait_drain(20);
    check("resume_addr", out_address, 5);
    check("resume_result", result, 5);
    check("final_done_cnt", done_cnt, 2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
